hazard_forward_unit: RTL and testbench

//  Pipeline-hazard controller for the 5-stage core. Tracks destination/source register metadata of
//  in-flight instructions (ID->EX->MEM->WB) and drives the 2-bit select codes of the EX-stage ALU

---
 rtl/core_pkg.sv | 38 +++
 rtl/fwd_select.sv | 39 +++
 rtl/hazard_forward_unit.sv | 109 ++++++++++
 tb/tb_hazard_forward_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared pipeline-hazard definitions: forwarding select codes and per-stage slot layouts.
// The same select codes drive the EX-stage operand three-input muxes.
package core_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int FWD_SEL_W = 2;

    localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rs1;
        logic [RF_ADDR_W-1:0] rs2;
        logic                 uses_rs1;
        logic                 uses_rs2;
        logic [RF_ADDR_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } hazard_slot_t;

    // Past EX only the producer side of a slot is ever consulted.
    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic                 reg_write;
    } retire_slot_t;

    function automatic retire_slot_t to_retire(input hazard_slot_t s);
        retire_slot_t r;
        r.valid     = s.valid;
        r.rd        = s.rd;
        r.reg_write = s.reg_write;
        return r;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source operand.
// The MEM producer is younger than WB, so it wins when both match.
module fwd_select
    import core_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_src,
    input  logic                  ex_uses,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [SEL_W-1:0]      sel
);

    logic consumer;
    logic match_mem;
    logic match_wb;

    // x0 reads as constant zero, so it never takes a bypass.
    assign consumer  = ex_valid & ex_uses & (ex_src != '0);
    assign match_mem = consumer & mem_valid & mem_reg_write & (mem_rd == ex_src);
    assign match_wb  = consumer & wb_valid & wb_reg_write & (wb_rd == ex_src);

    always_comb begin
        sel = SEL_W'(FWD_RF);
        if (match_mem) begin
            sel = SEL_W'(FWD_MEM);
        end else if (match_wb) begin
            sel = SEL_W'(FWD_WB);
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage core: EX operand forwarding selects,
// load-use stall/bubble, branch flush of IF/ID, and a saturating stall counter.
module hazard_forward_unit
    import core_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_flush,
    output logic [SEL_W-1:0]      forward_a,
    output logic [SEL_W-1:0]      forward_b,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush_id,
    output logic [CNT_W-1:0]      stall_count
);

    hazard_slot_t id_slot;
    hazard_slot_t ex_q;
    retire_slot_t mem_q;
    retire_slot_t wb_q;
    logic         load_use;

    always_comb begin
        id_slot           = '0;
        id_slot.valid     = id_valid;
        id_slot.rs1       = id_rs1;
        id_slot.rs2       = id_rs2;
        id_slot.uses_rs1  = id_uses_rs1;
        id_slot.uses_rs2  = id_uses_rs2;
        id_slot.rd        = id_rd;
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;
    end

    // A load in EX cannot feed the instruction in ID until it reaches WB.
    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                      ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_q.rd)));

    // A taken branch squashes the dependent anyway, so it overrides load-use.
    assign stall    = load_use & ~ex_flush;
    assign bubble   = stall;
    assign flush_id = ex_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_count <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= to_retire(ex_q);
            if (bubble || ex_flush) begin
                ex_q <= '0;
            end else begin
                ex_q <= id_slot;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W),
        .SEL_W      (SEL_W)
    ) u_fwd_a (
        .ex_valid      (ex_q.valid),
        .ex_src        (ex_q.rs1),
        .ex_uses       (ex_q.uses_rs1),
        .mem_valid     (mem_q.valid),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_valid      (wb_q.valid),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_q.rd),
        .sel           (forward_a)
    );

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W),
        .SEL_W      (SEL_W)
    ) u_fwd_b (
        .ex_valid      (ex_q.valid),
        .ex_src        (ex_q.rs2),
        .ex_uses       (ex_q.uses_rs2),
        .mem_valid     (mem_q.valid),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_valid      (wb_q.valid),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_q.rd),
        .sel           (forward_b)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: instruction-stream model feeding a scoreboard queue,
// plus directed checks on the classic hazard sequences and counter saturation.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_flush;

    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        stall;
    logic        bubble;
    logic        flush_id;
    logic [31:0] stall_count;

    logic [1:0]  s_fa;
    logic [1:0]  s_fb;
    logic        s_st;
    logic        s_bb;
    logic        s_fl;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall        (stall),
        .bubble       (bubble),
        .flush_id     (flush_id),
        .stall_count  (stall_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    hazard_forward_unit #(.CNT_W(2)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .forward_a    (s_fa),
        .forward_b    (s_fb),
        .stall        (s_st),
        .bubble       (s_bb),
        .flush_id     (s_fl),
        .stall_count  (s_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic        fl;
        logic [31:0] cnt;
        logic [1:0]  cs;
    } exp_t;

    localparam instr_t NOP = '0;

    exp_t   sb[$];
    instr_t m_ex, m_mem, m_wb;
    logic [31:0] m_cnt;
    logic [1:0]  m_cnt_s;
    logic [1:0]  o_fa, o_fb;
    logic        o_st, o_fl;

    function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2, input logic rw, input logic mr);
        instr_t i;
        i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.u1 = u1; i.u2 = u2; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic logic [1:0] exp_sel(input instr_t ex, input bit opb, input instr_t mem, input instr_t wb);
        logic [4:0] src;
        logic       u;
        src = opb ? ex.rs2 : ex.rs1;
        u   = opb ? ex.u2 : ex.u1;
        if (!ex.v || !u || src == 5'd0) return 2'b00;
        if (mem.v && mem.rw && mem.rd == src) return 2'b10;
        if (wb.v && wb.rw && wb.rd == src) return 2'b01;
        return 2'b00;
    endfunction

    // One cycle: drive ID/flush/reset, predict, sample at negedge, then advance the model.
    task automatic step(input string tag, input instr_t id, input logic fl, input logic rst);
        exp_t e;
        logic hz;
        id_valid = id.v; id_rs1 = id.rs1; id_rs2 = id.rs2;
        id_uses_rs1 = id.u1; id_uses_rs2 = id.u2; id_rd = id.rd;
        id_reg_write = id.rw; id_mem_read = id.mr;
        ex_flush = fl; reset = rst;
        hz = m_ex.v && m_ex.mr && (m_ex.rd != 5'd0) && id.v &&
             ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
        e.fa  = exp_sel(m_ex, 1'b0, m_mem, m_wb);
        e.fb  = exp_sel(m_ex, 1'b1, m_mem, m_wb);
        e.st  = hz && !fl;
        e.fl  = fl;
        e.cnt = m_cnt;
        e.cs  = m_cnt_s;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check_val({tag, "_fa"}, 32'(forward_a), 32'(e.fa));
        check_val({tag, "_fb"}, 32'(forward_b), 32'(e.fb));
        check_val({tag, "_stall"}, 32'(stall), 32'(e.st));
        check_val({tag, "_bubble"}, 32'(bubble), 32'(e.st));
        check_val({tag, "_flush"}, 32'(flush_id), 32'(e.fl));
        check_val({tag, "_cnt"}, stall_count, e.cnt);
        check_val({tag, "_cnt_sat"}, 32'(s_cnt), 32'(e.cs));
        o_fa = forward_a; o_fb = forward_b; o_st = stall; o_fl = flush_id;
        @(posedge clk);
        #1;
        if (rst) begin
            m_ex = NOP; m_mem = NOP; m_wb = NOP; m_cnt = '0; m_cnt_s = '0;
        end else begin
            if (e.st) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt_s != 2'b11) m_cnt_s = m_cnt_s + 2'd1;
            end
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (e.st || fl) ? NOP : id;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t ld8, use8, a5, u5, s7;
        reset = 1'b1; ex_flush = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_ex = NOP; m_mem = NOP; m_wb = NOP; m_cnt = '0; m_cnt_s = '0;
        step("init", NOP, 1'b0, 1'b0);
        check_val("reset_cnt", stall_count, 32'd0);

        // add x5,x1,x2 ; add x6,x5,x3
        step("t1a", mk(5'd5, 5'd1, 5'd2, 1, 1, 1, 0), 1'b0, 1'b0);
        step("t1b", mk(5'd6, 5'd5, 5'd3, 1, 1, 1, 0), 1'b0, 1'b0);
        step("t1c", NOP, 1'b0, 1'b0);
        check_val("t1_fa_mem", 32'(o_fa), 32'(2'b10));
        check_val("t1_no_stall", 32'(o_st), 32'd0);
        step("t1d", NOP, 1'b0, 1'b0);
        step("t1e", NOP, 1'b0, 1'b0);

        // add x5 ; nop ; sub x7,x4,x5
        a5 = mk(5'd5, 5'd1, 5'd2, 1, 1, 1, 0);
        s7 = mk(5'd7, 5'd4, 5'd5, 1, 1, 1, 0);
        step("t2a", a5, 1'b0, 1'b0);
        step("t2b", NOP, 1'b0, 1'b0);
        step("t2c", s7, 1'b0, 1'b0);
        step("t2d", NOP, 1'b0, 1'b0);
        check_val("t2_fb_wb", 32'(o_fb), 32'(2'b01));
        // two producers of x5: younger (MEM) wins
        u5 = mk(5'd10, 5'd5, 5'd0, 1, 0, 1, 0);
        step("t2e", a5, 1'b0, 1'b0);
        step("t2f", a5, 1'b0, 1'b0);
        step("t2g", u5, 1'b0, 1'b0);
        step("t2h", NOP, 1'b0, 1'b0);
        check_val("t2_fa_prio", 32'(o_fa), 32'(2'b10));
        step("t2i", NOP, 1'b0, 1'b0);
        step("t2j", NOP, 1'b0, 1'b0);

        // ld x8 ; add x9,x8,x1
        step("rst3", NOP, 1'b0, 1'b1);
        ld8  = mk(5'd8, 5'd2, 5'd0, 1, 0, 1, 1);
        use8 = mk(5'd9, 5'd8, 5'd1, 1, 1, 1, 0);
        step("t3a", ld8, 1'b0, 1'b0);
        step("t3b", use8, 1'b0, 1'b0);
        check_val("t3_stall", 32'(o_st), 32'd1);
        step("t3c", use8, 1'b0, 1'b0);
        check_val("t3_stall_once", 32'(o_st), 32'd0);
        step("t3d", NOP, 1'b0, 1'b0);
        check_val("t3_fa_wb", 32'(o_fa), 32'(2'b01));
        check_val("t3_cnt", stall_count, 32'd1);
        step("t3e", NOP, 1'b0, 1'b0);

        // x0 is never forwarded
        step("t4a", mk(5'd0, 5'd1, 5'd2, 1, 1, 1, 0), 1'b0, 1'b0);
        step("t4b", mk(5'd3, 5'd0, 5'd0, 1, 1, 1, 0), 1'b0, 1'b0);
        step("t4c", NOP, 1'b0, 1'b0);
        check_val("t4_fa_x0", 32'(o_fa), 32'(2'b00));
        check_val("t4_fb_x0", 32'(o_fb), 32'(2'b00));
        step("t4d", NOP, 1'b0, 1'b0);

        // flush beats load-use; EX invalid afterwards
        step("t5a", ld8, 1'b0, 1'b0);
        step("t5b", use8, 1'b1, 1'b0);
        check_val("t5_stall", 32'(o_st), 32'd0);
        check_val("t5_flush", 32'(o_fl), 32'd1);
        step("t5c", use8, 1'b0, 1'b0);
        check_val("t5_ex_invalid", 32'(o_fa), 32'(2'b00));
        step("t5d", NOP, 1'b0, 1'b0);
        step("t5e", NOP, 1'b0, 1'b0);

        // repeated load-use: narrow counter saturates, wide one keeps counting
        step("rst7", NOP, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("t7a", ld8, 1'b0, 1'b0);
            step("t7b", use8, 1'b0, 1'b0);
            step("t7c", use8, 1'b0, 1'b0);
        end
        step("t7d", NOP, 1'b0, 1'b0);
        check_val("t7_cnt", stall_count, 32'd5);
        check_val("t7_cnt_sat", 32'(s_cnt), 32'd3);

        // reset sampled during a stall cycle
        step("t6a", ld8, 1'b0, 1'b0);
        step("t6b", use8, 1'b0, 1'b1);
        check_val("t6_pre_stall", 32'(o_st), 32'd1);
        step("t6c", use8, 1'b0, 1'b0);
        check_val("t6_stall", 32'(o_st), 32'd0);
        check_val("t6_fa", 32'(o_fa), 32'd0);
        check_val("t6_cnt", stall_count, 32'd0);
        step("t6d", NOP, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
